nb_agc_loop: RTL and testbench

- Narrowband AGC loop downstream of the subcarrier DDC; closes the loop on its gain input.
- Consumes the DDC's 18-bit I/Q output and sample strobe, estimates magnitude, averages over a block and compares to a setpoint.
- Integrates the error and drives the 21-bit nbAgcGain word (exponent [20:16], mantissa [15:0]) back into the DDC's variable-gain stage.
- Setpoint, loop gain, limits and modes are microprocessor-programmable.

---
 rtl/nb_agc_pkg.sv | 42 ++++
 rtl/nb_agc_regs.sv | 111 +++++++++++
 rtl/nb_agc_loop.sv | 176 +++++++++++++++++
 tb/tb_nb_agc_loop.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nb_agc_pkg.sv
// Shared widths, register map and reset values for the narrowband AGC loop.
// Optional deadband register is enabled with NB_AGC_DEADBAND_EN.
package nb_agc_pkg;

    localparam int unsigned GAIN_W = 21;
    localparam int unsigned MAG_W  = 19;
    localparam int unsigned ERR_W  = 20;
    localparam int unsigned FRAC_W = 11;
    localparam int unsigned INT_W  = GAIN_W + FRAC_W + 1;

    localparam logic [2:0] OFS_SETPOINT = 3'd0;
    localparam logic [2:0] OFS_CONTROL  = 3'd1;
    localparam logic [2:0] OFS_UPPER    = 3'd2;
    localparam logic [2:0] OFS_LOWER    = 3'd3;
    localparam logic [2:0] OFS_MANUAL   = 3'd4;
    localparam logic [2:0] OFS_AVGMAG   = 3'd5;
    localparam logic [2:0] OFS_GAIN     = 3'd6;
    localparam logic [2:0] OFS_DEADBAND = 3'd7;

    localparam logic [MAG_W-1:0]  SETPOINT_RST = 19'h10000;
    localparam logic [GAIN_W-1:0] UPPER_RST    = 21'h1FFFFF;
    localparam logic [GAIN_W-1:0] LOWER_RST    = '0;
    localparam logic [MAG_W-1:0]  DEADBAND_RST = '0;

    localparam int unsigned CTRL_SHIFT_LSB = 0;
    localparam int unsigned CTRL_SHIFT_W   = 5;
    localparam int unsigned CTRL_FREEZE    = 8;
    localparam int unsigned CTRL_MANUAL    = 9;
    localparam logic [CTRL_SHIFT_W-1:0] SHIFT_MAX = 5'd12;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/nb_agc_regs.sv
// Microprocessor register file for the AGC loop: byte-lane writes and read mux.
// Register 7 (deadband) exists only when NB_AGC_DEADBAND_EN is defined.
module nb_agc_regs
    import nb_agc_pkg::*;
#(
    parameter logic [GAIN_W-1:0] RESET_GAIN = 21'h08000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cs,
    input  logic [3:0]              i_wr,
    input  logic [2:0]              i_ofs,
    input  logic [31:0]             i_din,
    output logic [31:0]             o_dout,
    input  logic [MAG_W-1:0]        i_avg_mag,
    input  logic [GAIN_W-1:0]       i_gain,
    output logic [MAG_W-1:0]        o_setpoint,
    output logic [CTRL_SHIFT_W-1:0] o_loop_shift,
    output logic                    o_freeze,
    output logic                    o_manual,
    output logic [GAIN_W-1:0]       o_upper,
    output logic [GAIN_W-1:0]       o_lower,
    output logic [GAIN_W-1:0]       o_manual_gain
`ifdef NB_AGC_DEADBAND_EN
    ,
    output logic [MAG_W-1:0]        o_deadband
`endif
);

    logic [MAG_W-1:0]        r_setpoint;
    logic [CTRL_SHIFT_W-1:0] r_loop_shift;
    logic                    r_freeze;
    logic                    r_manual;
    logic [GAIN_W-1:0]       r_upper;
    logic [GAIN_W-1:0]       r_lower;
    logic [GAIN_W-1:0]       r_manual_gain;
`ifdef NB_AGC_DEADBAND_EN
    logic [MAG_W-1:0]        r_deadband;
`endif

    logic [3:0]  w_be;
    logic [31:0] w_merge;

    assign w_be = i_cs ? i_wr : '0;
    // Partial-lane writes merge into the current readback image of the register.
    assign w_merge = byte_merge(o_dout, i_din, w_be);

    always_comb begin
        o_dout = '0;
        case (i_ofs)
            OFS_SETPOINT: o_dout[MAG_W-1:0] = r_setpoint;
            OFS_CONTROL: begin
                o_dout[CTRL_SHIFT_LSB +: CTRL_SHIFT_W] = r_loop_shift;
                o_dout[CTRL_FREEZE]                    = r_freeze;
                o_dout[CTRL_MANUAL]                    = r_manual;
            end
            OFS_UPPER:    o_dout[GAIN_W-1:0] = r_upper;
            OFS_LOWER:    o_dout[GAIN_W-1:0] = r_lower;
            OFS_MANUAL:   o_dout[GAIN_W-1:0] = r_manual_gain;
            OFS_AVGMAG:   o_dout[MAG_W-1:0]  = i_avg_mag;
            OFS_GAIN:     o_dout[GAIN_W-1:0] = i_gain;
`ifdef NB_AGC_DEADBAND_EN
            OFS_DEADBAND: o_dout[MAG_W-1:0]  = r_deadband;
`endif
            default:      o_dout = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_setpoint    <= SETPOINT_RST;
            r_loop_shift  <= '0;
            r_freeze      <= 1'b0;
            r_manual      <= 1'b0;
            r_upper       <= UPPER_RST;
            r_lower       <= LOWER_RST;
            r_manual_gain <= RESET_GAIN;
`ifdef NB_AGC_DEADBAND_EN
            r_deadband    <= DEADBAND_RST;
`endif
        end else if (|w_be) begin
            case (i_ofs)
                OFS_SETPOINT: r_setpoint <= w_merge[MAG_W-1:0];
                OFS_CONTROL: begin
                    r_loop_shift <= w_merge[CTRL_SHIFT_LSB +: CTRL_SHIFT_W];
                    r_freeze     <= w_merge[CTRL_FREEZE];
                    r_manual     <= w_merge[CTRL_MANUAL];
                end
                OFS_UPPER:    r_upper       <= w_merge[GAIN_W-1:0];
                OFS_LOWER:    r_lower       <= w_merge[GAIN_W-1:0];
                OFS_MANUAL:   r_manual_gain <= w_merge[GAIN_W-1:0];
`ifdef NB_AGC_DEADBAND_EN
                OFS_DEADBAND: r_deadband    <= w_merge[MAG_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    assign o_setpoint    = r_setpoint;
    assign o_loop_shift  = r_loop_shift;
    assign o_freeze      = r_freeze;
    assign o_manual      = r_manual;
    assign o_upper       = r_upper;
    assign o_lower       = r_lower;
    assign o_manual_gain = r_manual_gain;
`ifdef NB_AGC_DEADBAND_EN
    assign o_deadband    = r_deadband;
`endif

endmodule

// File: rtl/nb_agc_loop.sv
// Narrowband AGC loop: |I|+|Q| block average, setpoint error, clamped integrator -> DDC gain.
// NB_AGC_DEADBAND_EN adds a programmable error deadband (register 7).
module nb_agc_loop
    import nb_agc_pkg::*;
#(
    parameter int unsigned AVG_LOG2   = 4,
    parameter logic [20:0] RESET_GAIN = 21'h08000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr0,
    input  logic        wr1,
    input  logic        wr2,
    input  logic        wr3,
    input  logic [12:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        syncIn,
    input  logic [17:0] iIn,
    input  logic [17:0] qIn,
    output logic [20:0] nbAgcGain,
    output logic        gainValid,
    output logic [18:0] avgMag
);

    localparam int unsigned ACC_W = MAG_W + AVG_LOG2;
    localparam int unsigned SUM_W = INT_W + 1;

    logic [MAG_W-1:0]        w_setpoint;
    logic [CTRL_SHIFT_W-1:0] w_loop_shift;
    logic                    w_freeze;
    logic                    w_manual;
    logic [GAIN_W-1:0]       w_upper;
    logic [GAIN_W-1:0]       w_lower;
    logic [GAIN_W-1:0]       w_manual_gain;
`ifdef NB_AGC_DEADBAND_EN
    logic [MAG_W-1:0]        w_deadband;
`endif
    logic                    w_addr_unused;

    assign w_addr_unused = ^{addr[12:5], addr[1:0]};

    nb_agc_regs #(
        .RESET_GAIN (RESET_GAIN)
    ) u_regs (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cs          (cs),
        .i_wr          ({wr3, wr2, wr1, wr0}),
        .i_ofs         (addr[4:2]),
        .i_din         (din),
        .o_dout        (dout),
        .i_avg_mag     (avgMag),
        .i_gain        (nbAgcGain),
        .o_setpoint    (w_setpoint),
        .o_loop_shift  (w_loop_shift),
        .o_freeze      (w_freeze),
        .o_manual      (w_manual),
        .o_upper       (w_upper),
        .o_lower       (w_lower),
        .o_manual_gain (w_manual_gain)
`ifdef NB_AGC_DEADBAND_EN
        ,
        .o_deadband    (w_deadband)
`endif
    );

    function automatic logic [16:0] sat_abs(input logic [17:0] x);
        if (x == 18'h20000) return 17'h1FFFF;
        else if (x[17])     return 17'(~x + 18'd1);
        else                return x[16:0];
    endfunction

    logic                    r_v0, r_v1, r_v2, r_v3;
    logic [MAG_W-1:0]        r_mag0;
    logic [AVG_LOG2-1:0]     r_cnt;
    logic [ACC_W-1:0]        r_acc;
    logic [MAG_W-1:0]        r_avg1, r_avg2, r_avg3;
    logic signed [ERR_W-1:0] r_err2;
    logic [INT_W-1:0]        r_integ;
    logic [GAIN_W-1:0]       r_gain;
    logic                    r_gvalid;
    logic [MAG_W-1:0]        r_avgmag;

    logic [MAG_W-1:0]        w_mag;
    logic [ACC_W-1:0]        w_acc_sum;
    logic signed [ERR_W-1:0] w_err_raw, w_err;
    logic [CTRL_SHIFT_W-1:0] w_shift;
    logic [SUM_W-1:0]        w_step, w_sum;
    logic [GAIN_W-1:0]       w_int, w_hi_lim;
    logic                    w_neg, w_ovf;
    logic [INT_W-1:0]        w_integ_next;

    assign w_mag     = MAG_W'(sat_abs(iIn)) + MAG_W'(sat_abs(qIn));
    assign w_acc_sum = r_acc + ACC_W'(r_mag0);
    assign w_err_raw = $signed({1'b0, w_setpoint}) - $signed({1'b0, r_avg1});

`ifdef NB_AGC_DEADBAND_EN
    logic [ERR_W-1:0] w_err_mag;
    assign w_err_mag = w_err_raw[ERR_W-1] ? -w_err_raw : w_err_raw;
    assign w_err     = (w_err_mag <= {1'b0, w_deadband}) ? '0 : w_err_raw;
`else
    assign w_err = w_err_raw;
`endif

    assign w_shift  = (w_loop_shift > SHIFT_MAX) ? SHIFT_MAX : w_loop_shift;
    assign w_step   = {{(SUM_W-ERR_W){r_err2[ERR_W-1]}}, r_err2} << w_shift;
    assign w_sum    = {1'b0, r_integ} + w_step;
    assign w_neg    = w_sum[SUM_W-1];
    // Bit 32 set on a non-negative sum means the integer part overflowed 21 bits.
    assign w_ovf    = w_sum[INT_W-1];
    assign w_int    = w_sum[FRAC_W +: GAIN_W];
    assign w_hi_lim = (w_lower > w_upper) ? w_lower : w_upper;

    always_comb begin
        w_integ_next = w_sum[INT_W-1:0];
        if (w_neg || (!w_ovf && (w_int < w_lower))) begin
            w_integ_next = {1'b0, w_lower, {FRAC_W{1'b0}}};
        end else if (w_ovf || (w_int > w_upper)) begin
            w_integ_next = {1'b0, w_hi_lim, {FRAC_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_mag0   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_avg1   <= '0;
            r_avg2   <= '0;
            r_avg3   <= '0;
            r_err2   <= '0;
            r_integ  <= {1'b0, RESET_GAIN, {FRAC_W{1'b0}}};
            r_gain   <= RESET_GAIN;
            r_gvalid <= 1'b0;
            r_avgmag <= '0;
        end else begin
            r_v0   <= syncIn;
            r_mag0 <= w_mag;

            r_v1 <= 1'b0;
            if (r_v0) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    r_acc  <= '0;
                    r_avg1 <= w_acc_sum[ACC_W-1:AVG_LOG2];
                    r_v1   <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end

            r_v2   <= r_v1;
            r_avg2 <= r_avg1;
            r_err2 <= w_err;

            r_v3   <= r_v2;
            r_avg3 <= r_avg2;
            if (r_v2 && !w_freeze) r_integ <= w_integ_next;

            r_gain   <= w_manual ? w_manual_gain : r_integ[FRAC_W +: GAIN_W];
            r_gvalid <= r_v3;
            if (r_v3) r_avgmag <= r_avg3;
        end
    end

    assign nbAgcGain = r_gain;
    assign gainValid = r_gvalid;
    assign avgMag    = r_avgmag;

endmodule

// File: tb/tb_nb_agc_loop.sv
// Directed self-checking bench for nb_agc_loop with hand-computed expectations.
module tb_nb_agc_loop;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, wr3 = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        syncIn = 1'b0;
    logic [17:0] iIn = '0, qIn = '0;
    logic [20:0] nbAgcGain;
    logic        gainValid;
    logic [18:0] avgMag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned gv_seen  = 0;

    always #5 clk = ~clk;

    nb_agc_loop #(
        .AVG_LOG2   (4),
        .RESET_GAIN (21'h08000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .wr0       (wr0),
        .wr1       (wr1),
        .wr2       (wr2),
        .wr3       (wr3),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .syncIn    (syncIn),
        .iIn       (iIn),
        .qIn       (qIn),
        .nbAgcGain (nbAgcGain),
        .gainValid (gainValid),
        .avgMag    (avgMag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        syncIn = 1'b0;
        cs     = 1'b0;
        {wr3, wr2, wr1, wr0} = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic reg_wr(input logic [2:0] ofs, input logic [31:0] data,
                          input logic [3:0] be, input logic sel);
        @(negedge clk);
        cs   = sel;
        {wr3, wr2, wr1, wr0} = be;
        addr = {8'd0, ofs, 2'b00};
        din  = data;
        @(negedge clk);
        cs   = 1'b0;
        {wr3, wr2, wr1, wr0} = '0;
    endtask

    task automatic reg_rd(input string tag, input logic [2:0] ofs, input logic [31:0] exp);
        @(negedge clk);
        addr = {8'd0, ofs, 2'b00};
        #1;
        check(tag, dout, exp);
    endtask

    task automatic send_samples(input logic [17:0] i, input logic [17:0] q, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gainValid) gv_seen++;
            syncIn = 1'b1;
            iIn    = i;
            qIn    = q;
        end
        @(negedge clk);
        if (gainValid) gv_seen++;
        syncIn = 1'b0;
    endtask

    // Last sample is taken on edge P; outputs must change on edge P+4 exactly.
    task automatic run_block(input string pfx, input logic [17:0] i, input logic [17:0] q,
                             input int n, input logic [31:0] exp_avg, input logic [31:0] exp_gain);
        send_samples(i, q, n);
        repeat (3) @(negedge clk);
        check({pfx, "_gv_early"}, 32'(gainValid), 32'd0);
        @(negedge clk);
        check({pfx, "_gv"},   32'(gainValid), 32'd1);
        check({pfx, "_gain"}, 32'(nbAgcGain), exp_gain);
        check({pfx, "_avg"},  32'(avgMag),    exp_avg);
        @(negedge clk);
        check({pfx, "_gv_pulse"}, 32'(gainValid), 32'd0);
    endtask

    initial begin
        do_reset();

        check("rst_gain", 32'(nbAgcGain), 32'h08000);
        check("rst_gv",   32'(gainValid), 32'd0);
        check("rst_avg",  32'(avgMag),    32'd0);
        reg_rd("rd_setpoint", 3'd0, 32'h10000);
        reg_rd("rd_control",  3'd1, 32'h0);
        reg_rd("rd_upper",    3'd2, 32'h1FFFFF);
        reg_rd("rd_lower",    3'd3, 32'h0);
        reg_rd("rd_manual",   3'd4, 32'h08000);
        reg_rd("rd_avgmag",   3'd5, 32'h0);
        reg_rd("rd_gainreg",  3'd6, 32'h08000);
        reg_rd("rd_reg7",     3'd7, 32'h0);

        reg_wr(3'd1, 32'hFFFF_FFFF, 4'hF, 1'b1);
        reg_rd("rd_ctrl_unused", 3'd1, 32'h31F);
        reg_wr(3'd1, 32'h0, 4'hF, 1'b1);
        reg_wr(3'd7, 32'hFFFF_FFFF, 4'hF, 1'b1);
`ifdef NB_AGC_DEADBAND_EN
        reg_rd("rd_reg7_wr", 3'd7, 32'h7FFFF);
        reg_wr(3'd7, 32'h0, 4'hF, 1'b1);
`else
        reg_rd("rd_reg7_wr", 3'd7, 32'h0);
`endif

        run_block("conv", 18'h08000, 18'h0, 16, 32'h08000, 32'h08010);
        reg_rd("rd_avg_conv",  3'd5, 32'h08000);
        reg_rd("rd_gain_conv", 3'd6, 32'h08010);

        do_reset();
        reg_wr(3'd2, 32'hFFFF_FF20, 4'b0001, 1'b1);
        reg_rd("rd_upper_b0", 3'd2, 32'h1FFF20);
        reg_wr(3'd2, 32'h0000_8000, 4'b0110, 1'b1);
        reg_rd("rd_upper_b12", 3'd2, 32'h08020);
        reg_wr(3'd2, 32'h0, 4'hF, 1'b0);
        reg_rd("rd_upper_nocs", 3'd2, 32'h08020);
        run_block("upper1", 18'h08000, 18'h0, 16, 32'h08000, 32'h08010);
        run_block("upper2", 18'h08000, 18'h0, 16, 32'h08000, 32'h08020);
        run_block("upper3", 18'h08000, 18'h0, 16, 32'h08000, 32'h08020);

        do_reset();
        reg_wr(3'd0, 32'h0, 4'hF, 1'b1);
        reg_wr(3'd1, 32'h0000_000C, 4'hF, 1'b1);
        run_block("lower", 18'h1FFFF, 18'h1FFFF, 16, 32'h3FFFE, 32'h0);

        do_reset();
        reg_wr(3'd1, 32'h0000_001F, 4'hF, 1'b1);
        run_block("shiftcap", 18'h0FFFF, 18'h0, 16, 32'h0FFFF, 32'h08002);

        do_reset();
        run_block("sat", 18'h20000, 18'h20000, 16, 32'h3FFFE, 32'h07FA0);

        do_reset();
        reg_wr(3'd1, 32'h0000_0100, 4'hF, 1'b1);
        run_block("freeze", 18'h08000, 18'h0, 16, 32'h08000, 32'h08000);
        reg_wr(3'd4, 32'h0001_ABCD, 4'hF, 1'b1);
        check("man_not_yet", 32'(nbAgcGain), 32'h08000);
        reg_wr(3'd1, 32'h0000_0200, 4'hF, 1'b1);
        @(negedge clk);
        check("man_follow", 32'(nbAgcGain), 32'h1ABCD);
        run_block("manual", 18'h08000, 18'h0, 16, 32'h08000, 32'h1ABCD);
        reg_wr(3'd1, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        check("man_release", 32'(nbAgcGain), 32'h08010);

        send_samples(18'h08000, 18'h0, 7);
        do_reset();
        check("mid_rst_gain", 32'(nbAgcGain), 32'h08000);
        check("mid_rst_gv",   32'(gainValid), 32'd0);
        check("mid_rst_avg",  32'(avgMag),    32'd0);
        gv_seen = 0;
        send_samples(18'h08000, 18'h0, 15);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (gainValid) gv_seen++;
        end
        check("mid_no_early_gv", gv_seen, 32'd0);
        run_block("mid_block", 18'h08000, 18'h0, 1, 32'h08000, 32'h08010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
